junction_lamp_monitor: RTL and testbench

Independent safety monitor that sits on the lamp outputs of the junction traffic-light controller (R/A/G per signal head). It decodes each head's lamp pattern into a phase and checks three things: legal phase sequence, minimum dwell times, and that no conflicting heads are open together. On the first violation it latches a fault with a code and head index, and asserts an all-red request back to the controller's fail-safe input.

---
 rtl/junction_pkg.sv | 45 ++++
 rtl/lamp_head_tracker.sv | 68 ++++++
 rtl/junction_lamp_monitor.sv | 149 ++++++++++++++
 tb/tb_junction_lamp_monitor.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/junction_pkg.sv
// rtl/junction_pkg.sv - shared lamp phase / fault code types and phase helpers
package junction_pkg;

  typedef enum logic [2:0] {
    PH_UNKNOWN   = 3'd0,
    PH_RED       = 3'd1,
    PH_RED_AMBER = 3'd2,
    PH_GREEN     = 3'd3,
    PH_AMBER     = 3'd4
  } lamp_phase_e;

  typedef enum logic [2:0] {
    FC_NONE         = 3'd0,
    FC_ILLEGAL_LAMP = 3'd1,
    FC_BAD_SEQ      = 3'd2,
    FC_SHORT_GREEN  = 3'd3,
    FC_SHORT_AMBER  = 3'd4,
    FC_CONFLICT     = 3'd5
  } fault_code_e;

  // Pairs (0,3),(1,4),(2,5),(0,4),(1,5),(2,3) as bit i*6+j of a 6x6 matrix.
  localparam logic [35:0] DEFAULT_CONFLICT = 36'h0_0002_8C18;

  function automatic lamp_phase_e next_phase(input lamp_phase_e p);
    case (p)
      PH_RED:       next_phase = PH_RED_AMBER;
      PH_RED_AMBER: next_phase = PH_GREEN;
      PH_GREEN:     next_phase = PH_AMBER;
      PH_AMBER:     next_phase = PH_RED;
      default:      next_phase = PH_UNKNOWN;
    endcase
  endfunction

  // Illegal lamp patterns decode to PH_UNKNOWN, which never appears as a lit phase.
  function automatic lamp_phase_e decode_lamps(input logic r, input logic a, input logic g);
    case ({r, a, g})
      3'b100:  decode_lamps = PH_RED;
      3'b110:  decode_lamps = PH_RED_AMBER;
      3'b001:  decode_lamps = PH_GREEN;
      3'b010:  decode_lamps = PH_AMBER;
      default: decode_lamps = PH_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/lamp_head_tracker.sv
// rtl/lamp_head_tracker.sv - per-head phase tracking, dwell counting and local checks
module lamp_head_tracker
  import junction_pkg::*;
#(
  parameter int MIN_GREEN = 20,
  parameter int MIN_AMBER = 8,
  parameter int DW        = 5
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic lamp_r,
  input  logic lamp_a,
  input  logic lamp_g,
  output logic lamp_open,
  output logic illegal,
  output logic bad_seq,
  output logic short_green,
  output logic short_amber
);

  localparam int DWELL_MAX = (MIN_GREEN > MIN_AMBER) ? MIN_GREEN : MIN_AMBER;
  localparam logic [DW-1:0] DWELL_MAX_W = DW'(DWELL_MAX);
  localparam logic [DW-1:0] MIN_GREEN_W = DW'(MIN_GREEN);
  localparam logic [DW-1:0] MIN_AMBER_W = DW'(MIN_AMBER);

  lamp_phase_e       phase_q, phase_d, dec;
  logic [DW-1:0]     dwell_q, dwell_d;

  always_comb begin
    dec         = decode_lamps(lamp_r, lamp_a, lamp_g);
    phase_d     = phase_q;
    dwell_d     = dwell_q;
    lamp_open   = 1'b0;
    illegal     = 1'b0;
    bad_seq     = 1'b0;
    short_green = 1'b0;
    short_amber = 1'b0;
    if (en) begin
      illegal = (dec == PH_UNKNOWN);
      if (!illegal && dec != phase_q) begin
        phase_d = dec;
        dwell_d = DW'(1);
        // The first phase seen after reset is taken as-is.
        if (phase_q != PH_UNKNOWN) begin
          bad_seq     = (dec != next_phase(phase_q));
          short_green = (phase_q == PH_GREEN) && (dwell_q < MIN_GREEN_W);
          short_amber = (phase_q == PH_AMBER) && (dwell_q < MIN_AMBER_W);
        end
      end else if (dwell_q != DWELL_MAX_W) begin
        dwell_d = dwell_q + 1'b1;
      end
      lamp_open = !illegal && (phase_q != PH_UNKNOWN) &&
                  (dec == PH_GREEN || dec == PH_AMBER);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q <= PH_UNKNOWN;
      dwell_q <= '0;
    end else begin
      phase_q <= phase_d;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/junction_lamp_monitor.sv
// rtl/junction_lamp_monitor.sv - lamp sampling, conflict scan, fault priority and latch
module junction_lamp_monitor
  import junction_pkg::*;
#(
  parameter int                          N_HEADS   = 6,
  parameter int                          MIN_GREEN = 20,
  parameter int                          MIN_AMBER = 8,
  parameter logic [N_HEADS*N_HEADS-1:0]  CONFLICT  = DEFAULT_CONFLICT
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [N_HEADS-1:0]          R,
  input  logic [N_HEADS-1:0]          A,
  input  logic [N_HEADS-1:0]          G,
  input  logic                        fault_clr,
  output logic                        fault,
  output logic [2:0]                  fault_code,
  output logic [$clog2(N_HEADS)-1:0]  fault_head,
  output logic                        all_red_req
);

  localparam int HW        = $clog2(N_HEADS);
  localparam int DWELL_MAX = (MIN_GREEN > MIN_AMBER) ? MIN_GREEN : MIN_AMBER;
  localparam int DW        = $clog2(DWELL_MAX + 1);

  logic [N_HEADS-1:0] lamp_r_q, lamp_r_d, lamp_a_q, lamp_a_d, lamp_g_q, lamp_g_d;
  logic               sample_valid_q, sample_valid_d;
  logic               fault_q, fault_d;
  fault_code_e        fault_code_q, fault_code_d;
  logic [HW-1:0]      fault_head_q, fault_head_d;

  logic [N_HEADS-1:0] head_open, head_illegal, head_bad_seq, head_short_green, head_short_amber;
  logic [N_HEADS-1:0] conflict_hit;
  fault_code_e        viol_code;
  logic [HW-1:0]      viol_head;
  logic               viol;

  for (genvar k = 0; k < N_HEADS; k++) begin : g_head
    lamp_head_tracker #(
      .MIN_GREEN (MIN_GREEN),
      .MIN_AMBER (MIN_AMBER),
      .DW        (DW)
    ) u_tracker (
      .clk         (clk),
      .rstn        (rstn),
      .en          (sample_valid_q),
      .lamp_r      (lamp_r_q[k]),
      .lamp_a      (lamp_a_q[k]),
      .lamp_g      (lamp_g_q[k]),
      .lamp_open   (head_open[k]),
      .illegal     (head_illegal[k]),
      .bad_seq     (head_bad_seq[k]),
      .short_green (head_short_green[k]),
      .short_amber (head_short_amber[k])
    );
  end

  function automatic logic [HW-1:0] lowest_set(input logic [N_HEADS-1:0] v);
    lowest_set = '0;
    for (int k = N_HEADS - 1; k >= 0; k--) begin
      if (v[k]) lowest_set = HW'(k);
    end
  endfunction

  // Until the first edge after reset, lamp_q holds zeros rather than real lamps.
  always_comb begin
    lamp_r_d       = R;
    lamp_a_d       = A;
    lamp_g_d       = G;
    sample_valid_d = 1'b1;
  end

  always_comb begin
    conflict_hit = '0;
    for (int i = 0; i < N_HEADS; i++) begin
      for (int j = i + 1; j < N_HEADS; j++) begin
        if (CONFLICT[i*N_HEADS+j] && head_open[i] && head_open[j]) conflict_hit[i] = 1'b1;
      end
    end
  end

  // Written lowest priority first so that later matches override earlier ones.
  always_comb begin
    viol_code = FC_NONE;
    viol_head = '0;
    if (|head_short_amber) begin
      viol_code = FC_SHORT_AMBER;
      viol_head = lowest_set(head_short_amber);
    end
    if (|head_short_green) begin
      viol_code = FC_SHORT_GREEN;
      viol_head = lowest_set(head_short_green);
    end
    if (|head_bad_seq) begin
      viol_code = FC_BAD_SEQ;
      viol_head = lowest_set(head_bad_seq);
    end
    if (|head_illegal) begin
      viol_code = FC_ILLEGAL_LAMP;
      viol_head = lowest_set(head_illegal);
    end
    if (|conflict_hit) begin
      viol_code = FC_CONFLICT;
      viol_head = lowest_set(conflict_hit);
    end
    viol = (viol_code != FC_NONE);
  end

  always_comb begin
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    fault_head_d = fault_head_q;
    if (viol && (!fault_q || fault_clr)) begin
      fault_d      = 1'b1;
      fault_code_d = viol_code;
      fault_head_d = viol_head;
    end else if (fault_clr) begin
      fault_d      = 1'b0;
      fault_code_d = FC_NONE;
      fault_head_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lamp_r_q       <= '0;
      lamp_a_q       <= '0;
      lamp_g_q       <= '0;
      sample_valid_q <= 1'b0;
      fault_q        <= 1'b0;
      fault_code_q   <= FC_NONE;
      fault_head_q   <= '0;
    end else begin
      lamp_r_q       <= lamp_r_d;
      lamp_a_q       <= lamp_a_d;
      lamp_g_q       <= lamp_g_d;
      sample_valid_q <= sample_valid_d;
      fault_q        <= fault_d;
      fault_code_q   <= fault_code_d;
      fault_head_q   <= fault_head_d;
    end
  end

  assign fault       = fault_q;
  assign fault_code  = fault_code_q;
  assign fault_head  = fault_head_q;
  assign all_red_req = fault_q;

endmodule

// File: tb/tb_junction_lamp_monitor.sv
// tb/tb_junction_lamp_monitor.sv - randomized and directed bench with a behavioural lamp model
module tb_junction_lamp_monitor;

  localparam int N  = 6;
  localparam int MG = 4;
  localparam int MA = 2;
  localparam int DMAX = 4;
  localparam logic [2:0] P_RED = 3'b100, P_RA = 3'b110, P_GREEN = 3'b001, P_AMBER = 3'b010;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [N-1:0] R = '0, A = '0, G = '0;
  logic         fault_clr = 1'b0;
  logic         fault;
  logic [2:0]   fault_code;
  logic [2:0]   fault_head;
  logic         all_red_req;

  junction_lamp_monitor #(.N_HEADS(N), .MIN_GREEN(MG), .MIN_AMBER(MA)) dut (
    .clk(clk), .rstn(rstn), .R(R), .A(A), .G(G), .fault_clr(fault_clr),
    .fault(fault), .fault_code(fault_code), .fault_head(fault_head), .all_red_req(all_red_req)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: phases 0=RED 1=RED_AMBER 2=GREEN 3=AMBER, -1 unknown; legal move is +1 mod 4.
  int           m_phase [N];
  int           m_dwell [N];
  logic [N-1:0] m_r, m_a, m_g;
  bit           m_valid;
  bit           m_fault;
  int           m_code, m_head;
  int           pair_i [6] = '{0, 1, 2, 0, 1, 2};
  int           pair_j [6] = '{3, 4, 5, 4, 5, 3};
  int           dp [N];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int dec(input logic r, input logic a, input logic g);
    case ({r, a, g})
      3'b100:  return 0;
      3'b110:  return 1;
      3'b001:  return 2;
      3'b010:  return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [2:0] pat_of(input int p);
    case (p)
      0:       return P_RED;
      1:       return P_RA;
      2:       return P_GREEN;
      default: return P_AMBER;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_phase[k] = -1;
      m_dwell[k] = 0;
    end
    m_r = '0; m_a = '0; m_g = '0;
    m_valid = 0; m_fault = 0; m_code = 0; m_head = 0;
  endtask

  task automatic model_edge(input bit clr);
    int ph [N];
    bit ill [N], sq [N], sg [N], sa [N], op [N];
    int code, head;
    for (int k = 0; k < N; k++) begin
      ph[k] = dec(m_r[k], m_a[k], m_g[k]);
      ill[k] = 0; sq[k] = 0; sg[k] = 0; sa[k] = 0; op[k] = 0;
      if (m_valid) begin
        ill[k] = (ph[k] < 0);
        if (ph[k] >= 0 && m_phase[k] >= 0) begin
          op[k] = (ph[k] >= 2);
          if (ph[k] != m_phase[k]) begin
            sq[k] = (ph[k] != (m_phase[k] + 1) % 4);
            sg[k] = (m_phase[k] == 2) && (m_dwell[k] < MG);
            sa[k] = (m_phase[k] == 3) && (m_dwell[k] < MA);
          end
        end
      end
    end
    code = 0;
    head = N;
    for (int p = 0; p < 6; p++)
      if (op[pair_i[p]] && op[pair_j[p]] && pair_i[p] < head) head = pair_i[p];
    if (head < N) code = 5;
    for (int k = 0; k < N; k++) if (code == 0 && ill[k]) begin code = 1; head = k; end
    for (int k = 0; k < N; k++) if (code == 0 && sq[k])  begin code = 2; head = k; end
    for (int k = 0; k < N; k++) if (code == 0 && sg[k])  begin code = 3; head = k; end
    for (int k = 0; k < N; k++) if (code == 0 && sa[k])  begin code = 4; head = k; end
    if (code != 0 && (!m_fault || clr)) begin
      m_fault = 1; m_code = code; m_head = head;
    end else if (clr) begin
      m_fault = 0; m_code = 0; m_head = 0;
    end
    if (m_valid) begin
      for (int k = 0; k < N; k++) begin
        if (ph[k] >= 0 && ph[k] != m_phase[k]) begin
          m_phase[k] = ph[k];
          m_dwell[k] = 1;
        end else if (m_dwell[k] < DMAX) begin
          m_dwell[k]++;
        end
      end
    end
    m_r = R; m_a = A; m_g = G; m_valid = 1;
  endtask

  task automatic tick();
    model_edge(fault_clr);
    @(posedge clk);
    #1;
    check("fault", fault, m_fault);
    check("fault_code", fault_code, m_code);
    check("fault_head", fault_head, m_head);
    check("all_red_req", all_red_req, m_fault);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_head(input int k, input logic [2:0] p);
    R[k] = p[2]; A[k] = p[1]; G[k] = p[0];
  endtask

  task automatic all_red();
    R = '1; A = '0; G = '0;
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check("rst_fault", fault, 0);
    check("rst_code", fault_code, 0);
    check("rst_head", fault_head, 0);
    check("rst_all_red", all_red_req, 0);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    model_reset();
    all_red();
    @(posedge clk);
    #1;
    do_reset();
    ticks(3);

    // Legal cycle on head 0
    ticks(2);
    set_head(0, P_RA);    ticks(2);
    set_head(0, P_GREEN); ticks(4);
    set_head(0, P_AMBER); ticks(2);
    set_head(0, P_RED);   ticks(3);
    check("legal_cycle_fault", fault, 0);

    // Short green on head 1
    set_head(1, P_RA);    ticks(2);
    set_head(1, P_GREEN); ticks(3);
    set_head(1, P_AMBER); tick();
    check("short_green_not_yet", fault, 0);
    tick();
    check("short_green_fault", fault, 1);
    check("short_green_code", fault_code, 3);
    check("short_green_head", fault_head, 1);
    ticks(2);
    set_head(1, P_RED);   ticks(2);
    pulse_clr();
    check("clear_after_short", fault, 0);

    // Conflict and illegal in the same cycle
    set_head(0, P_GREEN); set_head(3, P_GREEN); set_head(5, 3'b111);
    ticks(2);
    check("conflict_code", fault_code, 5);
    check("conflict_head", fault_head, 0);

    // Reset mid-fault, then green from unknown
    all_red();
    set_head(0, P_GREEN);
    do_reset();
    ticks(6);
    check("green_from_unknown", fault, 0);
    set_head(0, P_AMBER); ticks(3);
    set_head(0, P_RED);   ticks(3);

    // Sequence skip, then a later illegal pattern must not overwrite
    set_head(2, P_GREEN); ticks(2);
    check("skip_code", fault_code, 2);
    check("skip_head", fault_head, 2);
    set_head(4, 3'b000);  ticks(2);
    check("latched_code", fault_code, 2);
    pulse_clr();
    check("clr_blocked", fault, 1);
    set_head(4, P_RED); set_head(2, P_AMBER); ticks(3);
    set_head(2, P_RED); ticks(3);
    pulse_clr();
    check("clr_fault", fault, 0);
    check("clr_all_red", all_red_req, 0);

    // Randomized traffic: heads 3..5 held red for the first half
    for (int k = 0; k < N; k++) dp[k] = 0;
    all_red();
    ticks(2);
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        int r;
        r = int'($urandom % 64);
        if (k >= 3 && c < 300) dp[k] = 0;
        else if (r < 7) dp[k] = (dp[k] + 1) % 4;
        else if (r == 7) dp[k] = (dp[k] + 2) % 4;
        if ($urandom % 40 == 0) set_head(k, 3'($urandom % 8));
        else set_head(k, pat_of(dp[k]));
      end
      fault_clr = ($urandom % 6 == 0);
      if ($urandom % 250 == 0) do_reset();
      tick();
    end
    fault_clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
